// File: rtl/accel_lock_master_if.sv
// Shared-bus port bundle between the lock-arbitrated accelerator master and the
// arbiter/accelerator fabric. data_i is combinational read data for addr_o.
interface accel_lock_master_if;
    logic [31:0] addr_o;
    logic        wr_en_o;
    logic        select_o;
    logic [31:0] data_o;
    logic [31:0] data_i;

    modport master (
        output addr_o,
        output wr_en_o,
        output select_o,
        output data_o,
        input  data_i
    );

    modport slave (
        input  addr_o,
        input  wr_en_o,
        input  select_o,
        input  data_o,
        output data_i
    );
endinterface

// File: rtl/accel_lock_master.sv
// Acquires a shared accelerator through a lock register, streams a job into it,
// polls for completion, reads the results back and releases the lock.
module accel_lock_master #(
    parameter int          CLIENT_ID   = 0,
    parameter logic [31:0] QUEUE_ADDR  = 32'd84,
    parameter int          N_WORDS     = 4,
    parameter logic [31:0] DATA_BASE   = 32'd0,
    parameter logic [31:0] CTRL_ADDR   = 32'd64,
    parameter logic [31:0] STATUS_ADDR = 32'd68,
    parameter logic [31:0] RESULT_BASE = 32'd32,
    parameter int          MAX_RETRY   = 16,
    parameter int          POLL_LIMIT  = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [32*N_WORDS-1:0]  job_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [32*N_WORDS-1:0]  result,
    accel_lock_master_if.master    bus
);

    localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int POLL_W  = $clog2(POLL_LIMIT + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(N_WORDS - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);
    localparam logic [POLL_W-1:0]  POLL_MAX    = POLL_W'(POLL_LIMIT);
    localparam logic [31:0]        CLIENT_WORD = 32'(CLIENT_ID);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_REQ     = 4'd1,
        ST_CHECK   = 4'd2,
        ST_WRITE   = 4'd3,
        ST_GO      = 4'd4,
        ST_POLL    = 4'd5,
        ST_READ    = 4'd6,
        ST_RELEASE = 4'd7,
        ST_FIN     = 4'd8
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [IDX_W-1:0]      idx_r;
    logic [IDX_W-1:0]      idx_s;
    logic [RETRY_W-1:0]    retry_r;
    logic [RETRY_W-1:0]    retry_s;
    logic [RETRY_W-1:0]    retry_inc_s;
    logic [POLL_W-1:0]     poll_r;
    logic [POLL_W-1:0]     poll_s;
    logic [POLL_W-1:0]     poll_inc_s;
    logic                  job_err_r;
    logic                  job_err_s;
    logic [32*N_WORDS-1:0] job_buf_r;
    logic [32*N_WORDS-1:0] result_r;
    logic [31:0]           word_s;

    logic                  busy_r;
    logic                  done_r;
    logic                  error_r;
    logic [31:0]           addr_r;
    logic [31:0]           addr_s;
    logic                  wr_en_r;
    logic                  wr_en_s;
    logic                  select_r;
    logic                  select_s;
    logic [31:0]           data_r;
    logic [31:0]           data_s;

    assign retry_inc_s = retry_r + RETRY_W'(1);
    assign poll_inc_s  = poll_r + POLL_W'(1);

    // Next-state, counter and sticky-error logic.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        retry_s   = retry_r;
        poll_s    = poll_r;
        job_err_s = job_err_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s   = ST_REQ;
                    idx_s     = '0;
                    retry_s   = '0;
                    poll_s    = '0;
                    job_err_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_s = ST_CHECK;
            end
            ST_CHECK: begin
                if (bus.data_i == CLIENT_WORD) begin
                    state_s = ST_WRITE;
                    idx_s   = '0;
                end else if (retry_inc_s == RETRY_MAX) begin
                    // Lock was never owned, so there is nothing to release.
                    retry_s   = retry_inc_s;
                    job_err_s = 1'b1;
                    state_s   = ST_FIN;
                end else begin
                    retry_s = retry_inc_s;
                    state_s = ST_REQ;
                end
            end
            ST_WRITE: begin
                if (idx_r == LAST_IDX) begin
                    state_s = ST_GO;
                    idx_s   = '0;
                end else begin
                    idx_s = idx_r + IDX_W'(1);
                end
            end
            ST_GO: begin
                state_s = ST_POLL;
            end
            ST_POLL: begin
                if (bus.data_i[0]) begin
                    state_s = ST_READ;
                    idx_s   = '0;
                end else if (poll_inc_s == POLL_MAX) begin
                    poll_s    = poll_inc_s;
                    job_err_s = 1'b1;
                    state_s   = ST_RELEASE;
                end else begin
                    poll_s = poll_inc_s;
                end
            end
            ST_READ: begin
                if (idx_r == LAST_IDX) begin
                    state_s = ST_RELEASE;
                    idx_s   = '0;
                end else begin
                    idx_s = idx_r + IDX_W'(1);
                end
            end
            ST_RELEASE: begin
                state_s = ST_FIN;
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign word_s = job_buf_r[32*idx_s +: 32];

    // Bus values for the cycle about to start; registered so data_i never reaches an output.
    always_comb begin
        addr_s   = 32'd0;
        wr_en_s  = 1'b0;
        select_s = 1'b0;
        data_s   = 32'd0;
        case (state_s)
            ST_REQ: begin
                addr_s   = QUEUE_ADDR;
                wr_en_s  = 1'b1;
                select_s = 1'b1;
                data_s   = 32'd1;
            end
            ST_CHECK: begin
                addr_s   = QUEUE_ADDR;
                select_s = 1'b1;
            end
            ST_WRITE: begin
                addr_s   = DATA_BASE + (32'(idx_s) << 2);
                wr_en_s  = 1'b1;
                select_s = 1'b1;
                data_s   = word_s;
            end
            ST_GO: begin
                addr_s   = CTRL_ADDR;
                wr_en_s  = 1'b1;
                select_s = 1'b1;
                data_s   = 32'd1;
            end
            ST_POLL: begin
                addr_s   = STATUS_ADDR;
                select_s = 1'b1;
            end
            ST_READ: begin
                addr_s   = RESULT_BASE + (32'(idx_s) << 2);
                select_s = 1'b1;
            end
            ST_RELEASE: begin
                addr_s   = QUEUE_ADDR;
                wr_en_s  = 1'b1;
                select_s = 1'b1;
                data_s   = 32'd0;
            end
            default: begin
                addr_s   = 32'd0;
                wr_en_s  = 1'b0;
                select_s = 1'b0;
                data_s   = 32'd0;
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            retry_r   <= '0;
            poll_r    <= '0;
            job_err_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            retry_r   <= retry_s;
            poll_r    <= poll_s;
            job_err_r <= job_err_s;
        end
    end

    // Job buffer and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            job_buf_r <= '0;
            result_r  <= '0;
        end else begin
            if ((state_r == ST_IDLE) && start) begin
                job_buf_r <= job_data;
            end
            if (state_r == ST_READ) begin
                result_r[32*idx_r +: 32] <= bus.data_i;
            end
        end
    end

    // Registered status and bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
            addr_r   <= 32'd0;
            wr_en_r  <= 1'b0;
            select_r <= 1'b0;
            data_r   <= 32'd0;
        end else begin
            busy_r   <= (state_s != ST_IDLE);
            done_r   <= (state_s == ST_FIN);
            error_r  <= (state_s == ST_FIN) && job_err_s;
            addr_r   <= addr_s;
            wr_en_r  <= wr_en_s;
            select_r <= select_s;
            data_r   <= data_s;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign result       = result_r;
    assign bus.addr_o   = addr_r;
    assign bus.wr_en_o  = wr_en_r;
    assign bus.select_o = select_r;
    assign bus.data_o   = data_r;

endmodule

// File: tb/tb_accel_lock_master.sv
// Randomized bench for accel_lock_master: a behavioural arbiter/accelerator
// responds on the bus and each job's transaction list is predicted from the rules.
module tb_accel_lock_master;

    localparam int          N   = 4;
    localparam logic [31:0] QA  = 32'd84;
    localparam logic [31:0] DB  = 32'd0;
    localparam logic [31:0] CA  = 32'd64;
    localparam logic [31:0] SA  = 32'd68;
    localparam logic [31:0] RB  = 32'd32;
    localparam int          MR  = 16;
    localparam int          PL  = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } txn_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [32*N-1:0] job_data = '0;
    logic           busy;
    logic           done;
    logic           error;
    logic [32*N-1:0] result;

    accel_lock_master_if bus();

    accel_lock_master #(
        .CLIENT_ID(0), .QUEUE_ADDR(QA), .N_WORDS(N), .DATA_BASE(DB),
        .CTRL_ADDR(CA), .STATUS_ADDR(SA), .RESULT_BASE(RB),
        .MAX_RETRY(MR), .POLL_LIMIT(PL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .job_data(job_data),
        .busy(busy), .done(done), .error(error), .result(result), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Environment configuration written by the tests.
    int          deny_cfg = 0;
    int          ready_cfg = 0;
    logic [30:0] status_hi = '0;
    logic [31:0] res_mem [N];

    // Environment state advanced by bus activity.
    int checks_seen = 0;
    int polls_seen = 0;

    txn_t bus_log[$];
    txn_t exp_q[$];
    bit   exp_err;
    logic [32*N-1:0] exp_result = '0;

    always @(posedge clk) begin
        if (rst || done) begin
            checks_seen <= 0;
            polls_seen  <= 0;
        end else if (bus.select_o && !bus.wr_en_o) begin
            if (bus.addr_o == QA) checks_seen <= checks_seen + 1;
            if (bus.addr_o == SA) polls_seen <= polls_seen + 1;
        end
    end

    always_comb begin
        bus.data_i = 32'd0;
        if (bus.select_o && !bus.wr_en_o) begin
            if (bus.addr_o == QA)
                bus.data_i = (checks_seen < deny_cfg) ? 32'd1 : 32'd0;
            else if (bus.addr_o == SA)
                bus.data_i = {status_hi, (polls_seen >= ready_cfg)};
            else if (bus.addr_o >= RB && bus.addr_o < RB + 32'd16)
                bus.data_i = res_mem[bus.addr_o[3:2]];
        end
    end

    always @(negedge clk) begin
        if (bus.select_o) bus_log.push_back({bus.addr_o, bus.wr_en_o, bus.data_o});
    end

    function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [31:0] d);
        return {a, w, d};
    endfunction

    function automatic logic [32*N-1:0] rand_words();
        logic [32*N-1:0] w;
        for (int k = 0; k < N; k++) w[32*k +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [32*N-1:0] pack_res();
        logic [32*N-1:0] w;
        for (int k = 0; k < N; k++) w[32*k +: 32] = res_mem[k];
        return w;
    endfunction

    // Predicted bus transactions and outcome for one job.
    task automatic build_exp(input int deny, input int ready, input logic [32*N-1:0] job);
        exp_q.delete();
        exp_err = 1'b0;
        if (deny >= MR) begin
            for (int i = 0; i < MR; i++) begin
                exp_q.push_back(mk(QA, 1'b1, 32'd1));
                exp_q.push_back(mk(QA, 1'b0, 32'd0));
            end
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i <= deny; i++) begin
            exp_q.push_back(mk(QA, 1'b1, 32'd1));
            exp_q.push_back(mk(QA, 1'b0, 32'd0));
        end
        for (int k = 0; k < N; k++) exp_q.push_back(mk(DB + 32'(4*k), 1'b1, job[32*k +: 32]));
        exp_q.push_back(mk(CA, 1'b1, 32'd1));
        if (ready < PL) begin
            for (int i = 0; i <= ready; i++) exp_q.push_back(mk(SA, 1'b0, 32'd0));
            for (int k = 0; k < N; k++) exp_q.push_back(mk(RB + 32'(4*k), 1'b0, 32'd0));
            exp_result = pack_res();
        end else begin
            for (int i = 0; i < PL; i++) exp_q.push_back(mk(SA, 1'b0, 32'd0));
            exp_err = 1'b1;
        end
        exp_q.push_back(mk(QA, 1'b1, 32'd0));
    endtask

    // Index of first disagreement between the log (from s) and exp_q, or -1.
    function automatic int seq_bad(input int s);
        int n = bus_log.size() - s;
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            if (bus_log[s+i].addr !== exp_q[i].addr || bus_log[s+i].wr !== exp_q[i].wr ||
                (exp_q[i].wr && bus_log[s+i].data !== exp_q[i].data))
                return i;
        end
        if (n != exp_q.size()) return (n < exp_q.size()) ? n : exp_q.size();
        return -1;
    endfunction

    // Starts a job, scrambles job_data after the latch, waits (bounded) for done.
    task automatic run_job(input logic [32*N-1:0] job, output int s, output bit got_done,
                           output bit got_err, output bit busy_seen, output bit one_shot);
        s = bus_log.size();
        got_done = 1'b0;
        got_err = 1'b0;
        @(negedge clk);
        start = 1'b1;
        job_data = job;
        @(negedge clk);
        start = 1'b0;
        job_data = rand_words();
        busy_seen = busy;
        for (int c = 0; c < 400 && !got_done; c++) begin
            if (done) begin
                got_done = 1'b1;
                got_err = error;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        one_shot = !done && !busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0 || error !== 1'b0) begin n_bad++; $display("FAIL reset_done_err: got %b/%b want 0/0", done, error); end
        n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
        n_cmp++;
        if ({bus.addr_o, bus.wr_en_o, bus.select_o, bus.data_o} !== '0) begin
            n_bad++; $display("FAIL reset_bus: got addr=%h wr=%b sel=%b data=%h want all 0",
                              bus.addr_o, bus.wr_en_o, bus.select_o, bus.data_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Full job with randomized environment; all per-job checks.
    task automatic do_job(input string name, input int deny, input int ready);
        int s; bit d, e, b, os; int bad;
        logic [32*N-1:0] job = rand_words();
        logic [32*N-1:0] prev = exp_result;
        deny_cfg = deny;
        ready_cfg = ready;
        status_hi = 31'($urandom);
        for (int k = 0; k < N; k++) res_mem[k] = $urandom;
        build_exp(deny, ready, job);
        run_job(job, s, d, e, b, os);
        n_cmp++; if (d !== 1'b1) begin n_bad++; $display("FAIL %s_done: got %b want 1", name, d); end
        n_cmp++; if (e !== exp_err) begin n_bad++; $display("FAIL %s_error: got %b want %b", name, e, exp_err); end
        n_cmp++; if (b !== 1'b1) begin n_bad++; $display("FAIL %s_busy: got %b want 1", name, b); end
        n_cmp++; if (os !== 1'b1) begin n_bad++; $display("FAIL %s_done_pulse: got %b want 1", name, os); end
        bad = seq_bad(s);
        n_cmp++;
        if (bad != -1) begin
            n_bad++;
            $display("FAIL %s_bus_seq: first difference at txn %0d, got %0d txns want %0d (deny=%0d ready=%0d)",
                     name, bad, bus_log.size() - s, exp_q.size(), deny, ready);
        end
        n_cmp++;
        if (result !== exp_result) begin
            n_bad++; $display("FAIL %s_result: got %h want %h (prev %h)", name, result, exp_result, prev);
        end
    endtask

    task automatic test_basic();
        do_job("basic", 0, 3);
    endtask

    task automatic test_retry();
        do_job("retry", 5, $urandom_range(0, 5));
    endtask

    task automatic test_lock_timeout();
        int s0 = bus_log.size();
        int bad_wr = 0;
        do_job("lock_timeout", 100, 2);
        for (int i = s0; i < bus_log.size(); i++) begin
            if (bus_log[i].wr && bus_log[i].addr != QA) bad_wr++;
            if (bus_log[i].wr && bus_log[i].addr == QA && bus_log[i].data == 32'd0) bad_wr++;
        end
        n_cmp++; if (bad_wr != 0) begin n_bad++; $display("FAIL lock_timeout_writes: got %0d release/data writes want 0", bad_wr); end
    endtask

    task automatic test_poll_timeout();
        do_job("poll_timeout", $urandom_range(0, 3), 1000);
    endtask

    task automatic test_back_to_back();
        int s; int bad; bit seen = 1'b0; bit got = 1'b0;
        logic [32*N-1:0] job = rand_words();
        deny_cfg = 0;
        ready_cfg = 4;
        for (int k = 0; k < N; k++) res_mem[k] = $urandom;
        build_exp(0, 4, job);
        s = bus_log.size();
        @(negedge clk); start = 1'b1; job_data = job;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (bus.select_o && bus.addr_o == SA) seen = 1'b1;
            else @(negedge clk);
        end
        start = 1'b1; job_data = rand_words();
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        n_cmp++; if (!(seen && got)) begin n_bad++; $display("FAIL b2b_progress: poll seen %b done seen %b want 1/1", seen, got); end
        repeat (10) @(negedge clk);
        bad = seq_bad(s);
        n_cmp++; if (bad != -1) begin n_bad++; $display("FAIL b2b_bus_seq: first difference at txn %0d, got %0d txns want %0d", bad, bus_log.size() - s, exp_q.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_after: busy got %b want 0", busy); end
        n_cmp++; if (result !== exp_result) begin n_bad++; $display("FAIL b2b_result: got %h want %h", result, exp_result); end
    endtask

    task automatic test_reset_mid();
        int s2; int rel = 0; bit in_read = 1'b0;
        deny_cfg = 0;
        ready_cfg = 2;
        for (int k = 0; k < N; k++) res_mem[k] = $urandom;
        @(negedge clk); start = 1'b1; job_data = rand_words();
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 100 && !in_read; c++) begin
            if (bus.select_o && !bus.wr_en_o && bus.addr_o >= RB && bus.addr_o < RB + 32'd16) in_read = 1'b1;
            else @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_result = '0;
        n_cmp++; if (!in_read) begin n_bad++; $display("FAIL rstmid_reach_read: got 0 want 1"); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin n_bad++; $display("FAIL rstmid_status: busy/done/err got %b%b%b want 000", busy, done, error); end
        n_cmp++;
        if ({bus.addr_o, bus.wr_en_o, bus.select_o, bus.data_o} !== '0) begin
            n_bad++; $display("FAIL rstmid_bus: got addr=%h wr=%b sel=%b data=%h want all 0",
                              bus.addr_o, bus.wr_en_o, bus.select_o, bus.data_o);
        end
        n_cmp++; if (result !== exp_result) begin n_bad++; $display("FAIL rstmid_result: got %h want 0", result); end
        s2 = bus_log.size();
        repeat (10) @(negedge clk);
        for (int i = s2; i < bus_log.size(); i++) if (bus_log[i].wr && bus_log[i].addr == QA) rel++;
        n_cmp++; if (rel != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_release: got %0d release writes busy=%b want 0/0", rel, busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int deny = ($urandom_range(0, 5) == 0) ? MR + 2 : $urandom_range(0, 7);
            int ready = $urandom_range(0, 10);
            do_job("random", deny, ready);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) res_mem[k] = 32'd0;
        test_reset();
        test_basic();
        test_retry();
        test_lock_timeout();
        test_poll_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/accel_lock_master.md
ACCEL_LOCK_MASTER -- requirements
Module: accel_lock_master

Interface
REQ-001 Parameter CLIENT_ID, default 0, this core's index at the lock arbiter.
REQ-002 Parameter QUEUE_ADDR, default 32'd84, lock register address.
REQ-003 Parameter N_WORDS, default 4, job and result words per transaction (1..16).
REQ-004 Parameter DATA_BASE, default 32'd0, first accelerator input-word address; word k at DATA_BASE+4k.
REQ-005 Parameter CTRL_ADDR, default 32'd64, accelerator start register.
REQ-006 Parameter STATUS_ADDR, default 32'd68, accelerator status register; bit 0 = done.
REQ-007 Parameter RESULT_BASE, default 32'd32, first result-word address; word k at RESULT_BASE+4k.
REQ-008 Parameter MAX_RETRY, default 16, lock-acquire attempts before error.
REQ-009 Parameter POLL_LIMIT, default 1024, status polls before timeout.
REQ-010 Ports: clk in 1 clock; rst in 1 synchronous active-high reset; start in 1 job request; job_data in 32*N_WORDS input words (word k at bits 32k+31:32k); busy out 1; done out 1 one-cycle completion pulse; error out 1 valid with done; result out 32*N_WORDS result words; addr_o out 32; wr_en_o out 1; select_o out 1; data_o out 32 write data; data_i in 32 read data from arbiter (combinational, same cycle as addr_o).

Function
REQ-011 States: IDLE, REQ, CHECK, WRITE, GO, POLL, READ, RELEASE, FIN.
REQ-012 IDLE: select_o=0, wr_en_o=0, addr_o=0, data_o=0; start=1 latches job_data into internal buffer, clears retry/poll counters, -> REQ next cycle.
REQ-013 start while busy=1 SHALL be ignored; job_data changes after latch SHALL not affect the job.
REQ-014 REQ: addr_o=QUEUE_ADDR, wr_en_o=1, select_o=1, data_o=1, one cycle, -> CHECK.
REQ-015 CHECK: addr_o=QUEUE_ADDR, wr_en_o=0, select_o=1; data_i==CLIENT_ID -> WRITE; else retry count +1 and -> REQ, or -> FIN with error=1 when count reaches MAX_RETRY (no release write, lock never owned).
REQ-016 WRITE: N_WORDS consecutive cycles, word index k 0..N_WORDS-1, addr_o=DATA_BASE+4k, data_o=buffered word k, wr_en_o=1, select_o=1; after k=N_WORDS-1 -> GO.
REQ-017 GO: one cycle write of 32'd1 to CTRL_ADDR, -> POLL.
REQ-018 POLL: read STATUS_ADDR each cycle (wr_en_o=0, select_o=1); data_i[0]=1 -> READ; poll counter +1 otherwise; reaching POLL_LIMIT sets sticky error and -> RELEASE.
REQ-019 READ: N_WORDS cycles, addr_o=RESULT_BASE+4k, wr_en_o=0, select_o=1; data_i captured into result word k at the clock edge ending that cycle; -> RELEASE.
REQ-020 RELEASE: one cycle write of 32'd0 to QUEUE_ADDR with select_o=1, -> FIN.
REQ-021 FIN: done=1 for exactly one cycle, error reflects job outcome, -> IDLE; busy=1 in every state except IDLE.
REQ-022 result SHALL hold its value from last completed READ until next READ; on timeout error result is not updated.
REQ-023 Word index and counters SHALL be sized by $clog2 of their limits and wrap only via explicit clear, never modulo overflow.
REQ-024 All outputs SHALL be decoded from registered state/counters only (data_i feeds no output combinationally).
REQ-025 Lock assumed lost only through own release; no transaction to non-QUEUE_ADDR addresses SHALL occur outside WRITE/GO/POLL/READ.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, error=0, result=0, counters=0, bus outputs 0 on the following cycle.
REQ-027 Reset mid-transaction SHALL not issue a release write; the arbiter's own reset frees the lock.

Verification
REQ-028 CLIENT_ID=0, lock free, status done after 3 polls, N_WORDS=4 -> bus sequence REQ, CHECK(data_i=0), 4 writes to 0,4,8,12, write 1 to 64, 3+1 reads of 68, reads of 32..44, write 0 to 84, done=1 error=0, result equals returned words.
REQ-029 Lock held by client 1 for 5 attempts then freed -> 5 REQ/CHECK pairs, then acquire, job completes with error=0.
REQ-030 Lock never granted, MAX_RETRY=16 -> 16 REQ/CHECK pairs, done=1 error=1, no write to 84 with data 0, no DATA_BASE writes.
REQ-031 Status bit 0 never set, POLL_LIMIT=8 -> 8 polls, release write of 0 to 84, done=1 error=1, result unchanged.
REQ-032 start pulsed again during POLL and rst asserted in READ -> second start ignored; after rst busy=0, all bus outputs 0, no release write.
